// File: rtl/pid_pwm_pkg.sv
// Shared constants, FSM state type and prescaler sizing for the PID-driven PWM generator.
// Combinational definitions only; no flow control.
package pid_pwm_pkg;
    localparam int DUTY_W  = 8;
    localparam int CNT_MAX = 254;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int presc_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction
endpackage

// File: rtl/pid_pwm_channel.sv
// One PWM channel: pending/shadow duty registers and the registered compare.
// pwm follows cnt by one HCLK; duty_valid is always accepted, never back-pressured.
module pid_pwm_channel #(
    parameter int DUTY_W = pid_pwm_pkg::DUTY_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              duty_valid,
    input  logic [DUTY_W-1:0] duty,
    input  logic              load,
    input  logic              run,
    input  logic [DUTY_W-1:0] cnt,
    output logic              pwm
);
    import pid_pwm_pkg::*;

    logic [DUTY_W-1:0] pending;
    logic [DUTY_W-1:0] shadow;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending <= '0;
            shadow  <= '0;
            pwm     <= 1'b0;
        end else begin
            if (duty_valid)
                pending <= duty;
            // A strobe landing on the load edge bypasses pending so it is not lost for a period.
            if (load)
                shadow <= duty_valid ? duty : pending;
            pwm <= run && (cnt < shadow);
        end
    end
endmodule

// File: rtl/pid_pwm_gen.sv
// Two-channel PWM generator fed by a PID controller: FSM, prescaler and 0..254 period counter.
// Outputs registered, one HCLK after count changes; duty strobes always accepted.
module pid_pwm_gen #(
    parameter int PRESCALE = 4,
    parameter int DUTY_W   = pid_pwm_pkg::DUTY_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_0,
    input  logic [DUTY_W-1:0] duty_1,
    input  logic              duty_valid,
    output logic              pwm_0,
    output logic              pwm_1,
    output logic              period_start,
    output logic [DUTY_W-1:0] cnt_out
);
    import pid_pwm_pkg::*;

    localparam int PW = presc_w(PRESCALE);

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     presc;
    logic [PW-1:0]     presc_nxt;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_nxt;
    logic              start_nxt;
    logic              tick;
    logic              load;
    logic              run;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            presc        <= presc_nxt;
            cnt          <= cnt_nxt;
            period_start <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        load      = 1'b0;
        tick      = (presc == PW'(PRESCALE - 1));
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                    cnt_nxt   = '0;
                    start_nxt = 1'b1;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    cnt_nxt   = '0;
                end else begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (cnt == DUTY_W'(CNT_MAX)) begin
                            cnt_nxt   = '0;
                            start_nxt = 1'b1;
                            load      = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with enable makes the outputs drop on the same edge the FSM leaves RUN.
    assign run     = (state == RUN) && enable;
    assign cnt_out = cnt;

    pid_pwm_channel #(.DUTY_W(DUTY_W)) u_ch0 (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .duty_valid (duty_valid),
        .duty       (duty_0),
        .load       (load),
        .run        (run),
        .cnt        (cnt),
        .pwm        (pwm_0)
    );

    pid_pwm_channel #(.DUTY_W(DUTY_W)) u_ch1 (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .duty_valid (duty_valid),
        .duty       (duty_1),
        .load       (load),
        .run        (run),
        .cnt        (cnt),
        .pwm        (pwm_1)
    );
endmodule

// File: tb/tb_pid_pwm_gen.sv
// Bench for pid_pwm_gen: directed table, period-level duty measurements and a randomized run
// against an elapsed-time reference model.
module tb_pid_pwm_gen;
    localparam int PRESCALE = 4;
    localparam int DW       = 8;
    localparam int PER      = 255 * PRESCALE;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          enable;
    logic          duty_valid;
    logic [DW-1:0] duty_0;
    logic [DW-1:0] duty_1;
    logic          pwm_0;
    logic          pwm_1;
    logic          period_start;
    logic [DW-1:0] cnt_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    pid_pwm_gen #(.PRESCALE(PRESCALE), .DUTY_W(DW)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .enable       (enable),
        .duty_0       (duty_0),
        .duty_1       (duty_1),
        .duty_valid   (duty_valid),
        .pwm_0        (pwm_0),
        .pwm_1        (pwm_1),
        .period_start (period_start),
        .cnt_out      (cnt_out)
    );

    // Reference model: time elapsed since entering RUN, count derived arithmetically.
    bit            m_run;
    int            m_t;
    logic [DW-1:0] m_pend0, m_pend1, m_shad0, m_shad1;

    function automatic int cnt_of(input int t);
        return (t / PRESCALE) % 255;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_t = 0;
        m_pend0 = '0; m_pend1 = '0; m_shad0 = '0; m_shad1 = '0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({pwm_0, pwm_1, period_start, cnt_out});
    endfunction

    task automatic cycle(input bit en, input bit v, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input bit use_model);
        logic [DW-1:0] c;
        bit e_p0, e_p1, e_ps;
        logic [DW-1:0] e_cnt;
        enable = en; duty_valid = v; duty_0 = d0; duty_1 = d1;
        c    = DW'(cnt_of(m_t));
        e_p0 = m_run && en && (c < m_shad0);
        e_p1 = m_run && en && (c < m_shad1);
        e_ps = 1'b0;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_t = 0; e_ps = 1'b1;
                m_shad0 = v ? d0 : m_pend0;
                m_shad1 = v ? d1 : m_pend1;
            end
        end else if (!en) begin
            m_run = 1'b0; m_t = 0;
        end else begin
            m_t++;
            if (m_t % PER == 0) begin
                e_ps = 1'b1;
                m_shad0 = v ? d0 : m_pend0;
                m_shad1 = v ? d1 : m_pend1;
            end
        end
        if (v) begin m_pend0 = d0; m_pend1 = d1; end
        e_cnt = DW'(cnt_of(m_t));
        @(posedge HCLK); #1;
        if (use_model) check("model", outs(), 32'({e_p0, e_p1, e_ps, e_cnt}));
    endtask

    // Measures one full period: samples 1..PER after a period_start sample.
    task automatic measure(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int strobe_step,
                           output int hi0, output int hi1, output int len);
        hi0 = 0; hi1 = 0; len = 0;
        for (int i = 0; i < 2 * PER && !period_start; i++) cycle(1'b1, 1'b0, d0, d1, 1'b1);
        if (!period_start) begin
            check("align_timeout", 32'(period_start), 32'd1);
            return;
        end
        do begin
            len++;
            cycle(1'b1, len == strobe_step, d0, d1, 1'b1);
            hi0 += int'(pwm_0);
            hi1 += int'(pwm_1);
        end while (!period_start && len < 2 * PER);
    endtask

    typedef struct {
        bit            en;
        bit            v;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        bit            p0;
        bit            p1;
        bit            ps;
        logic [DW-1:0] cnt;
    } vec_t;

    vec_t tbl[10];
    int   hi0, hi1, len;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'd128, 8'd64,  1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 8'd1};
        tbl[6] = '{1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{1'b0, 1'b1, 8'd0,   8'd255, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 8'd0};
        tbl[9] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 8'd0};

        HRESETn = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_0 = '0; duty_1 = '0;
        model_reset();
        @(posedge HCLK); @(posedge HCLK); #1;
        check("reset_state", outs(), 32'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].en, tbl[i].v, tbl[i].d0, tbl[i].d1, 1'b0);
            check($sformatf("tbl%0d", i), outs(),
                  32'({tbl[i].p0, tbl[i].p1, tbl[i].ps, tbl[i].cnt}));
        end

        // Extremes: duty 0 never high, duty 255 always high, across three wraps.
        for (int p = 0; p < 3; p++) begin
            measure(8'd0, 8'd255, -1, hi0, hi1, len);
            check("ext_hi0", 32'(hi0), 32'd0);
            check("ext_hi1", 32'(hi1), 32'(PER));
        end

        // Steady state with 128/64.
        cycle(1'b1, 1'b1, 8'd128, 8'd64, 1'b1);
        for (int p = 0; p < 2; p++) begin
            measure(8'd128, 8'd64, -1, hi0, hi1, len);
            check("steady_hi0", 32'(hi0), 32'd512);
            check("steady_hi1", 32'(hi1), 32'd256);
            check("steady_len", 32'(len), 32'(PER));
        end

        // Mid-period strobe at count 100 must not affect the running period.
        measure(8'd200, 8'd64, 401, hi0, hi1, len);
        check("mid_cur_hi0", 32'(hi0), 32'd512);
        measure(8'd200, 8'd64, -1, hi0, hi1, len);
        check("mid_next_hi0", 32'(hi0), 32'd800);

        // Strobe on the wrap tick goes straight to shadow.
        measure(8'd32, 8'd64, PER, hi0, hi1, len);
        check("wrap_cur_hi0", 32'(hi0), 32'd800);
        measure(8'd32, 8'd64, -1, hi0, hi1, len);
        check("wrap_new_hi0", 32'(hi0), 32'd128);

        // Enable drop at count 50 with a pending strobe, then re-enable.
        for (int i = 0; i < 2 * PER && cnt_out != 8'd50; i++)
            cycle(1'b1, cnt_out == 8'd40, 8'd100, 8'd10, 1'b1);
        check("drop_reach50", 32'(cnt_out), 32'd50);
        cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check("drop_pwm0", 32'(pwm_0), 32'd0);
        check("drop_cnt", 32'(cnt_out), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
        check("reen_pstart", 32'(period_start), 32'd1);
        measure(8'd0, 8'd0, -1, hi0, hi1, len);
        check("reen_hi0", 32'(hi0), 32'd400);
        check("reen_hi1", 32'(hi1), 32'd40);

        // Randomized run against the model.
        for (int i = 0; i < 6000; i++) begin
            logic [DW-1:0] r0, r1;
            r0 = ($urandom_range(0, 3) == 0) ? 8'd0 : ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
            r1 = DW'($urandom);
            cycle($urandom_range(0, 499) != 0, $urandom_range(0, 31) == 0, r0, r1, 1'b1);
        end

        // Asynchronous reset mid-RUN while pwm_0 is high.
        cycle(1'b1, 1'b1, 8'd128, 8'd64, 1'b1);
        for (int i = 0; i < 2 * PER && pwm_0 != 1'b1; i++) cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
        check("rst_pre_pwm0", 32'(pwm_0), 32'd1);
        #2 HRESETn = 1'b0;
        #1 check("rst_async", outs(), 32'd0);
        enable = 1'b0; duty_valid = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
        check("rst_restart_ps", 32'(period_start), 32'd1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pid_pwm_gen.md
PID_PWM_GEN -- requirements
Module: pid_pwm_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning HCLK cycles per PWM count step (legal range 1..256).
REQ-002 SHALL have parameter DUTY_W, default 8, meaning duty word width, matching the PID controller duty outputs.
REQ-003 SHALL have port HCLK  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  input  1  1 = generate PWM, 0 = outputs held low.
REQ-006 SHALL have port duty_0  input  DUTY_W  channel-0 duty from the PID controller (dout_0_pid).
REQ-007 SHALL have port duty_1  input  DUTY_W  channel-1 duty from the PID controller (dout_1_pid).
REQ-008 SHALL have port duty_valid  input  1  one-cycle strobe; duty_0/duty_1 are valid this cycle.
REQ-009 SHALL have port pwm_0  output  1  registered PWM, channel 0.
REQ-010 SHALL have port pwm_1  output  1  registered PWM, channel 1.
REQ-011 SHALL have port period_start  output  1  one-HCLK pulse when the period counter enters 0; used as the PID sample request.
REQ-012 SHALL have port cnt_out  output  DUTY_W  current period count, for debug and test.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (enable=0) and RUN.
REQ-014 IDLE->RUN on the first HCLK with enable=1: copy pending duties to shadow, clear prescaler and count to 0, pulse period_start.
REQ-015 RUN->IDLE on any HCLK with enable=0: clear prescaler and count, drive pwm_x low from the next edge; pending duties are retained.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 in RUN; tick when it equals PRESCALE-1, then wrap to 0.
REQ-017 Period counter SHALL advance only on tick and count 0..254; on tick at 254 it wraps to 0 (period = 255*PRESCALE HCLK).
REQ-018 duty_valid=1 SHALL capture duty_0/duty_1 into pending registers; the last strobe before a wrap wins.
REQ-019 Shadow duties SHALL load from pending only at wrap (254->0) or on IDLE->RUN; there is no mid-period update.
REQ-020 duty_valid coincident with the wrap tick SHALL load the newly strobed value straight into shadow.
REQ-021 pwm_x SHALL be registered as (state==RUN) && (count < shadow_x); latency is one HCLK after the count changes.
REQ-022 Duty 0 SHALL give constant low and duty 255 constant high, with no glitch at wrap; duty N gives N*PRESCALE high HCLKs per period.
REQ-023 period_start SHALL pulse for exactly one HCLK, on the edge where count becomes 0 (wrap or IDLE->RUN).
REQ-024 Comparisons SHALL be unsigned DUTY_W-bit; the prescaler width SHALL be clog2(PRESCALE), minimum 1 bit.

Reset
REQ-025 HRESETn=0 SHALL immediately force state=IDLE; pwm_0=0, pwm_1=0, period_start=0, cnt_out=0; prescaler, pending and shadow all 0.
REQ-026 On reset release the block SHALL stay in IDLE until enable=1; reset mid-period SHALL abandon the period with no completion.

Structure
REQ-027 Package pid_pwm_pkg SHALL hold DUTY_W, CNT_MAX=254 and the FSM state enum (IDLE, RUN).
REQ-028 SHALL instantiate sub-module pid_pwm_channel twice; it holds the pending/shadow registers and compare for one channel, and the top holds the FSM, prescaler and counter.

Verification
REQ-029 Reset: assert HRESETn=0 mid-RUN with pwm_0=1 -> pwm_0, pwm_1, period_start and cnt_out are 0 before the next HCLK edge.
REQ-030 Steady state: PRESCALE=4, duty_0=128, duty_1=64 strobed, enable=1 -> each 1020-HCLK period has pwm_0 high 512 cycles and pwm_1 high 256; period_start every 1020 cycles.
REQ-031 Extremes: duty_0=0, duty_1=255 -> pwm_0 constantly 0 and pwm_1 constantly 1 across 3 wraps.
REQ-032 Mid-period change: strobe duty_0=200 at count=100 with old duty 128 -> current period high 512 cycles, next period 800.
REQ-033 Coincident wrap: strobe duty_0=32 on the wrap tick -> the new period's pwm_0 is high 128 cycles.
REQ-034 Enable drop: enable=0 at count=50 -> pwm low next edge, count 0; re-enable -> period_start pulses and the retained pending duty is applied.
